// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit LE word count, LE data words, one write per word.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] part_q, part_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_new;

  assign in_ready  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign cpu_hold  = busy;
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign accept    = in_valid && in_ready;
  assign n_new     = {in_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LEN_LO;
          error_d    = 1'b0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          part_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = n_new;
          if (n_new == 16'd0) begin
            state_d = ST_DONE;
          end else if (32'(n_new) > DEPTH_WORDS) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          // Bytes shift in from the top so the first byte ends up in bits 7:0.
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {in_data, part_q};
            mem_addr_d  = BASE_ADDR + {14'b0, word_cnt_q, 2'b00};
            byte_idx_d  = '0;
            if (word_cnt_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
`endif
            end else begin
              word_cnt_d = word_cnt_q + 16'd1;
            end
          end else begin
            part_d     = {in_data, part_q[23:8]};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (in_data != csum_q) error_d = 1'b1;
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      part_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      part_q      <= part_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load vectors, write scoreboard, hand-written reset/boundary cases.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, error, cpu_hold;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      n;
    logic [3:0][31:0] words;
    logic             exp_err;
    logic [7:0]       csum_delta;
    logic             b2b;
    logic             start_mid;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];
  int          wr_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_we", 64'(mem_we), 64'd0);
      else chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] wgen(input logic [3:0][31:0] wt, input int unsigned k);
    logic [15:0] k16;
    k16 = k[15:0];
    return (k < 4) ? wt[k[1:0]] : {k16, ~k16};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_start, input logic chk_ready);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    if (chk_ready) chk("b2b_in_ready", 64'(in_ready), 64'd1);
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int t;
    t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    chk("done", 64'(done), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("done_status", {in_ready, busy, cpu_hold, error}, {3'b000, exp_err});
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_start", {busy, cpu_hold, done, error, in_ready}, 5'b11001);
  endtask

  task automatic do_load(input vec_t v);
    logic [31:0] w;
    logic [7:0]  cs;
    logic        ok;
    wr_cyc.delete();
    cs = 8'h00;
    start_load();
    send_byte(v.n[7:0], 1'b0, v.b2b);
    send_byte(v.n[15:8], 1'b0, v.b2b);
    ok = (v.n != 16'd0) && (32'(v.n) <= DEPTH);
    if (ok) begin
      for (int unsigned k = 0; k < 32'(v.n); k++)
        exp_q.push_back({BASE + 32'(4 * k), wgen(v.words, k)});
      for (int unsigned k = 0; k < 32'(v.n); k++) begin
        w = wgen(v.words, k);
        for (int unsigned j = 0; j < 4; j++) begin
          if (!v.b2b && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
          end
          cs = cs ^ w[8*j +: 8];
          send_byte(w[8*j +: 8], v.start_mid && k == 0 && j == 2, v.b2b);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs ^ v.csum_delta, 1'b0, v.b2b);
`endif
    end
    in_valid = 1'b0;
    wait_done(v.exp_err);
    if (v.b2b) begin
      chk("b2b_write_count", 64'(wr_cyc.size()), 64'd2);
      if (wr_cyc.size() >= 2) chk("b2b_write_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
    end
    repeat (3) tick();
    chk("error_sticky", 64'(error), 64'(v.exp_err));
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int NV = 7;
`else
  localparam int NV = 6;
`endif

  initial begin
    vec_t vecs[NV];
    vec_t v;
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    vecs[0].n = 16'd2;      vecs[0].words[0] = 32'h0000_0513; vecs[0].words[1] = 32'h0010_0593;
    vecs[1].n = 16'd0;
    vecs[2].n = 16'h1001;   vecs[2].exp_err = 1'b1;
    vecs[3].n = 16'd2;      vecs[3].words[0] = 32'h1122_3344; vecs[3].words[1] = 32'h5566_7788;
    vecs[3].b2b = 1'b1;
    vecs[4].n = 16'd3;      vecs[4].words[0] = 32'hDEAD_BEEF; vecs[4].words[1] = 32'h1234_5678;
    vecs[4].words[2] = 32'hA5A5_5A5A; vecs[4].start_mid = 1'b1;
    vecs[5].n = 16'd1;      vecs[5].words[0] = 32'h0000_0513;
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[6].n = 16'd1;      vecs[6].words[0] = 32'h0000_0513;
    vecs[6].csum_delta = 8'h01; vecs[6].exp_err = 1'b1;
`endif

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    chk("reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", {in_ready, busy, done, error, cpu_hold}, 5'b0);

    for (int i = 0; i < NV; i++) do_load(vecs[i]);

    // Reset mid-load after 6 data bytes of a 2-word load: word 0 already written, word 1 dropped.
    start_load();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    exp_q.push_back({BASE, 32'hCAFE_F00D});
    send_byte(8'h0D, 1'b0, 1'b0); send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'hFE, 1'b0, 1'b0); send_byte(8'hCA, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0); send_byte(8'h22, 1'b0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midload_reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold}, '0);
    chk("midload_first_word_written", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    v = '0;
    v.n = 16'd1;
    v.words[0] = 32'h0BAD_F00D;
    do_load(v);

    // Full-capacity load: N equal to DEPTH is accepted, last address BASE+4*(DEPTH-1).
    v = '0;
    v.n = 16'(DEPTH);
    v.words[0] = 32'h0102_0304; v.words[1] = 32'hF0E0_D0C0;
    v.words[2] = 32'h8000_0001; v.words[3] = 32'h7FFF_FFFE;
    do_load(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
